if_stage_fq: RTL and testbench

Parametrised instruction-fetch stage for the pipelined LoongArch CPU, the successor to the single-cycle fetch path. It generates sequential PCs, drives the synchronous-read inst SRAM, and buffers fetched {pc, inst} pairs in a FIFO fetch queue. The queue feeds decode through a valid/allowin handshake. Branch redirects flush the queue and squash the in-flight fetch, with zero bubble on the redirect request itself.

---
 rtl/if_stage_fq.sv | 112 +++++++++++
 tb/tb_if_stage_fq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage: sequential PC generation, sync-read inst SRAM request,
// and a FIFO fetch queue of {adef, pc, inst} feeding decode over valid/allowin.
module if_stage_fq #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned INST_W   = 32,
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     inst_sram_en,
  output logic [3:0]               inst_sram_we,
  output logic [PC_W-1:0]          inst_sram_addr,
  output logic [31:0]              inst_sram_wdata,
  input  logic [INST_W-1:0]        inst_sram_rdata,
  input  logic                     br_taken,
  input  logic [PC_W-1:0]          br_target,
  input  logic                     ds_allowin,
  output logic                     fs_to_ds_valid,
  output logic [PC_W+INST_W:0]     fs_to_ds_bus,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic              adef;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  inflight_pc;
  logic             inflight;
  logic             inflight_adef;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  fq_entry_t        fq_mem [FQ_DEPTH];

  logic [PC_W-1:0]  fetch_addr;
  logic [OCC_W-1:0] occupancy;
  logic             aligned;
  logic             space;
  logic             req;
  logic             push;
  logic             pop;

  // Request/push/pop decisions; occupancy counts the in-flight slot so a push never overflows.
  always_comb begin
    fetch_addr = br_taken ? br_target : pc;
    aligned    = (fetch_addr[1:0] == 2'b00);
    occupancy  = OCC_W'(count) + OCC_W'(inflight);
    space      = br_taken | (occupancy < OCC_W'(FQ_DEPTH));
    req        = ~reset & space;
    push       = inflight & ~br_taken;
    pop        = fs_to_ds_valid & ds_allowin & ~br_taken;
  end

  assign inst_sram_en    = req & aligned;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign inst_sram_addr  = fetch_addr;
  assign fs_to_ds_valid  = ~reset & (count != '0);
  assign fq_count        = reset ? '0 : count;
  assign fs_to_ds_bus    = fq_mem[head];

  // PC, in-flight tracking and queue bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_adef <= 1'b0;
      inflight_pc   <= '0;
      count         <= '0;
      head          <= '0;
      tail          <= '0;
    end else begin
      pc       <= req ? fetch_addr + PC_W'(4) : fetch_addr;
      inflight <= req;
      if (req) begin
        inflight_pc   <= fetch_addr;
        inflight_adef <= ~aligned;
      end
      if (br_taken) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage; misaligned fetches never read SRAM, so their inst is forced to zero.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fq_mem[tail].adef <= inflight_adef;
      fq_mem[tail].pc   <= inflight_pc;
      fq_mem[tail].inst <= inflight_adef ? '0 : inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage_fq.sv
// Self-checking bench for if_stage_fq: directed scenarios plus random allowin/branch
// traffic, checked every cycle against a queue-based reference model.
module tb_if_stage_fq;
  localparam int unsigned D = 4;
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic [2:0]  fq_count;

  always #5 clk = ~clk;

  if_stage_fq #(.PC_W(32), .INST_W(32), .FQ_DEPTH(D), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken(br_taken), .br_target(br_target), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .fq_count(fq_count)
  );

  // Sync-read SRAM: mem[addr] = addr ^ 0xffff0000; garbage when not enabled.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? (inst_sram_addr ^ 32'hffff0000) : 32'($urandom);

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RST_PC;
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = '0;
  logic [31:0] e_addr;
  logic        e_space;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle, then compare every output to the model's view.
  task automatic setin(input logic r, input logic b, input logic [31:0] t, input logic a);
    @(negedge clk);
    reset = r; br_taken = b; br_target = t; ds_allowin = a;
    #1;
    e_addr  = b ? t : m_pc;
    e_space = b || ((q.size() + int'(m_infl)) < D);
    chk("sram_we", 96'(inst_sram_we), 96'(0));
    chk("sram_wdata", 96'(inst_sram_wdata), 96'(0));
    if (r) begin
      chk("rst_en", 96'(inst_sram_en), 96'(0));
      chk("rst_valid", 96'(fs_to_ds_valid), 96'(0));
      chk("rst_count", 96'(fq_count), 96'(0));
    end else begin
      chk("sram_addr", 96'(inst_sram_addr), 96'(e_addr));
      chk("sram_en", 96'(inst_sram_en), 96'(e_space && (e_addr[1:0] == 2'b00)));
      chk("valid", 96'(fs_to_ds_valid), 96'(q.size() != 0));
      chk("fq_count", 96'(fq_count), 96'(q.size()));
      chk("count_bound", 96'(fq_count <= 3'(D)), 96'(1));
      if (q.size() != 0) chk("bus", 96'(fs_to_ds_bus), 96'(q[0]));
    end
  endtask

  // Advance the model across the clock edge using the inputs that were applied.
  task automatic adv();
    logic adef;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_pc   = RST_PC;
      m_infl = 1'b0;
    end else begin
      if (br_taken) q.delete();
      else begin
        if (q.size() != 0 && ds_allowin) void'(q.pop_front());
        if (m_infl) begin
          adef = (m_infl_pc[1:0] != 2'b00);
          q.push_back('{adef: adef, pc: m_infl_pc,
                        inst: adef ? 32'h0 : (m_infl_pc ^ 32'hffff0000)});
        end
      end
      m_infl    = e_space;
      m_infl_pc = e_addr;
      m_pc      = e_space ? e_addr + 32'd4 : e_addr;
    end
  endtask

  task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic a);
    setin(r, b, t, a);
    adv();
  endtask

  initial begin
    int          n_req;
    logic        seen;
    logic [31:0] first_addr;
    logic [31:0] t;

    reset = 1'b1; br_taken = 1'b0; br_target = '0; ds_allowin = 1'b1;

    // Reset release and steady streaming
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    setin(0, 0, 0, 1);
    chk("t1_addr0", 96'(inst_sram_addr), 96'(32'h1c000000));
    chk("t1_en0", 96'(inst_sram_en), 96'(1));
    adv();
    setin(0, 0, 0, 1);
    chk("t1_addr1", 96'(inst_sram_addr), 96'(32'h1c000004));
    chk("t1_valid_lat", 96'(fs_to_ds_valid), 96'(0));
    adv();
    setin(0, 0, 0, 1);
    chk("t1_addr2", 96'(inst_sram_addr), 96'(32'h1c000008));
    chk("t1_first_valid", 96'(fs_to_ds_valid), 96'(1));
    chk("t1_first_bus", 96'(fs_to_ds_bus), 96'({1'b0, 32'h1c000000, 32'he3ff0000}));
    adv();
    setin(0, 0, 0, 1);
    chk("t1_second_pc", 96'(fs_to_ds_bus[63:32]), 96'(32'h1c000004));
    adv();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    // Backpressure fills the queue, then drains in order
    cyc(1, 0, 0, 0);
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      setin(0, 0, 0, 0);
      if (inst_sram_en) n_req++;
      adv();
    end
    chk("t2_requests", 96'(n_req), 96'(4));
    setin(0, 0, 0, 0);
    chk("t2_full_count", 96'(fq_count), 96'(4));
    chk("t2_full_en", 96'(inst_sram_en), 96'(0));
    adv();
    seen = 1'b0; first_addr = '0;
    for (int k = 0; k < 4; k++) begin
      setin(0, 0, 0, 1);
      chk("t2_drain_pc", 96'(fs_to_ds_bus[63:32]), 96'(32'h1c000000 + 32'(k) * 32'd4));
      if (inst_sram_en && !seen) begin seen = 1'b1; first_addr = inst_sram_addr; end
      adv();
    end
    chk("t2_resume_addr", 96'(first_addr), 96'(32'h1c000010));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Redirect with count = 3 and a fetch in flight
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    setin(0, 1, 32'h1c000100, 0);
    chk("t3_pre_count", 96'(fq_count), 96'(3));
    chk("t3_br_addr", 96'(inst_sram_addr), 96'(32'h1c000100));
    chk("t3_br_en", 96'(inst_sram_en), 96'(1));
    adv();
    setin(0, 0, 0, 1);
    chk("t3_flushed", 96'(fq_count), 96'(0));
    adv();
    setin(0, 0, 0, 1);
    chk("t3_head", 96'(fs_to_ds_bus), 96'({1'b0, 32'h1c000100, 32'he3ff0100}));
    adv();
    setin(0, 0, 0, 1);
    chk("t3_next", 96'(fs_to_ds_bus[63:32]), 96'(32'h1c000104));
    adv();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Misaligned redirect produces an adef entry
    setin(0, 1, 32'h1c000102, 1);
    chk("t4_en_low", 96'(inst_sram_en), 96'(0));
    adv();
    setin(0, 0, 0, 1);
    chk("t4_next_addr", 96'(inst_sram_addr), 96'(32'h1c000106));
    adv();
    setin(0, 0, 0, 1);
    chk("t4_adef_entry", 96'(fs_to_ds_bus), 96'({1'b1, 32'h1c000102, 32'h0}));
    adv();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Random allowin / branch / occasional reset traffic
    for (int i = 0; i < 1000; i++) begin
      t = 32'h1c000000 + 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 7) == 0) t = t + 32'($urandom_range(1, 3));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, t,
          (i % 100) < 30 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    // Reset with count = 2 and a fetch in flight
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    setin(0, 0, 0, 1);
    chk("t6_count", 96'(fq_count), 96'(0));
    chk("t6_valid", 96'(fs_to_ds_valid), 96'(0));
    chk("t6_restart", 96'(inst_sram_addr), 96'(32'h1c000000));
    adv();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
